// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends start/8 data/parity/stop
// on device clock falls, samples the device ACK and reports completion or timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 3500,
    parameter int unsigned TIMEOUT_CYCLES = 420000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_BITS      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_clk_filt;
    logic [FLT_W-1:0] r_flt_cnt;
    logic             r_fall;

    logic [2:0]       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [3:0]       r_k, w_k_nx;
    logic [7:0]       r_data, w_data_nx;
    logic             r_nack, w_nack_nx;
    logic             r_clk_oe, w_clk_oe_nx;
    logic             r_dat_oe, w_dat_oe_nx;
    logic             r_ready, w_ready_nx;
    logic             r_done, w_done_nx;
    logic             r_err, w_err_nx;
    logic             w_timeout;
    logic             w_parity;

    // Synchronizers plus clock deglitch; a level change needs FILTER_LEN consecutive differing samples
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                r_flt_cnt  <= '0;
                r_clk_filt <= r_clk_s2;
                r_fall     <= ~r_clk_s2;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_parity  = ~^r_data;

    // Next-state and next-output logic; all outputs are registered from these values
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_k_nx      = r_k;
        w_data_nx   = r_data;
        w_nack_nx   = r_nack;
        w_clk_oe_nx = r_clk_oe;
        w_dat_oe_nx = r_dat_oe;
        w_ready_nx  = 1'b0;
        w_done_nx   = 1'b0;
        w_err_nx    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                w_ready_nx  = 1'b1;
                if (tx_valid && r_ready) begin
                    w_data_nx   = tx_data;
                    w_state_nx  = S_INHIBIT;
                    w_cnt_nx    = '0;
                    w_clk_oe_nx = 1'b1;
                    w_ready_nx  = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    w_state_nx  = S_START;
                    w_cnt_nx    = '0;
                    w_dat_oe_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_START: begin
                w_state_nx  = S_BITS;
                w_clk_oe_nx = 1'b0;
                w_k_nx      = 4'd0;
                w_cnt_nx    = '0;
            end
            S_BITS: begin
                if (r_fall) begin
                    w_cnt_nx = '0;
                    w_k_nx   = r_k + 4'd1;
                    if (r_k < 4'd8) begin
                        w_dat_oe_nx = ~r_data[r_k[2:0]];
                    end else if (r_k == 4'd8) begin
                        w_dat_oe_nx = ~w_parity;
                    end else begin
                        w_dat_oe_nx = 1'b0;
                        w_state_nx  = S_ACK;
                    end
                end else if (w_timeout) begin
                    w_state_nx  = S_IDLE;
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = 1'b0;
                    w_done_nx   = 1'b1;
                    w_err_nx    = 1'b1;
                    w_cnt_nx    = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (r_fall) begin
                    w_nack_nx  = r_dat_s2;
                    w_state_nx = S_WAIT_IDLE;
                    w_cnt_nx   = '0;
                end else if (w_timeout) begin
                    w_state_nx  = S_IDLE;
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = 1'b0;
                    w_done_nx   = 1'b1;
                    w_err_nx    = 1'b1;
                    w_cnt_nx    = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                // Bus idle: both lines released and high after the device's ACK
                if (r_clk_filt && r_dat_s2) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                    w_err_nx   = r_nack;
                    w_cnt_nx   = '0;
                end else if (w_timeout || r_fall) begin
                    w_cnt_nx = '0;
                    if (!r_fall) begin
                        w_state_nx  = S_IDLE;
                        w_clk_oe_nx = 1'b0;
                        w_dat_oe_nx = 1'b0;
                        w_done_nx   = 1'b1;
                        w_err_nx    = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                w_cnt_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_k      <= '0;
            r_data   <= '0;
            r_nack   <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_k      <= w_k_nx;
            r_data   <= w_data_nx;
            r_nack   <= w_nack_nx;
            r_clk_oe <= w_clk_oe_nx;
            r_dat_oe <= w_dat_oe_nx;
            r_ready  <= w_ready_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign tx_ready   = r_ready;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus with a simple PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 300;
    localparam int unsigned FLT  = 8;
    localparam int          HALF = 20;
    localparam int          LIMIT = 2000;

    logic       clk28 = 1'b0;
    logic       rst;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err;
    logic       dev_clk, dev_dat;
    logic       line_clk, line_dat;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_run = 0, last_oe_run = 0;
    int done_cnt = 0, dbl_done = 0, rdy_done = 0;
    logic done_prev = 1'b0;

    assign line_clk = dev_clk & ~ps2_clk_oe;
    assign line_dat = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk28      (clk28),
        .rst        (rst),
        .ps2_clk    (line_clk),
        .ps2_dat    (line_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk28 = ~clk28;

    // Bus monitor: clock-inhibit run length and tx_done pulse properties
    always @(negedge clk28) begin
        if (ps2_clk_oe === 1'b1) begin
            oe_run++;
        end else if (oe_run != 0) begin
            last_oe_run = oe_run;
            oe_run = 0;
        end
        if (tx_done === 1'b1) begin
            done_cnt++;
            if (done_prev) dbl_done++;
            if (tx_ready === 1'b1) rdy_done++;
        end
        done_prev = (tx_done === 1'b1);
    end

    task automatic tick;
        @(posedge clk28);
        #1;
    endtask

    task automatic clk_pulse(input int n);
        dev_clk = 1'b0;
        repeat (n) tick;
        dev_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < LIMIT) begin tick; n++; end
        n_checks++;
        if (n >= LIMIT) begin n_fail++; $display("FAIL send_ready_wait: tx_ready=%b expected 1", tx_ready); end
        tx_data  = d;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        n_checks++;
        if (ps2_clk_oe !== 1'b1) begin n_fail++; $display("FAIL accept_clk_oe: got %b expected 1", ps2_clk_oe); end
        n_checks++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL accept_ready: got %b expected 0", tx_ready); end
    endtask

    // Device: waits for inhibit release, clocks 11 edges sampling the data line before each fall,
    // optionally ACKs on the 11th edge; abort_e >= 0 asserts reset in the low phase of that edge.
    task automatic device_xfer(input logic ack, input int abort_e,
                               output logic [10:0] bits, output logic got_done, output logic err);
        int n;
        bits = '0; got_done = 1'b0; err = 1'b0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < LIMIT) begin tick; n++; end
        while (ps2_clk_oe !== 1'b0 && n < LIMIT) begin tick; n++; end
        n_checks++;
        if (n >= LIMIT) begin n_fail++; $display("FAIL release_wait: clk_oe=%b expected 0", ps2_clk_oe); return; end
        for (int e = 0; e < 11; e++) begin
            repeat (HALF) tick;
            bits[e] = line_dat;
            if (e == 10 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            if (e == abort_e) begin
                repeat (15) tick;
                rst = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1;
                tick;
                n_checks++;
                if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL rst_clk_oe: got %b expected 0", ps2_clk_oe); end
                n_checks++;
                if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dat_oe: got %b expected 0", ps2_dat_oe); end
                rst = 1'b0;
                return;
            end
            repeat (HALF) tick;
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
        n = 0;
        while (tx_done !== 1'b1 && n < LIMIT) begin tick; n++; end
        got_done = (tx_done === 1'b1);
        err = tx_err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        n_checks++;
        if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
        n_checks++;
        if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dat_oe: got %b expected 0", ps2_dat_oe); end
        n_checks++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
        n_checks++;
        if (tx_done !== 1'b0 || tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b expected 00", tx_done, tx_err); end
        rst = 1'b0;
        tick;
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", tx_ready); end
    endtask

    task automatic test_ack_ed;
        logic [10:0] bits; logic gd, er;
        send(8'hED);
        device_xfer(1'b1, -1, bits, gd, er);
        n_checks++;
        if (bits !== 11'h7DA) begin n_fail++; $display("FAIL ed_bits: got %h expected 7da", bits); end
        n_checks++;
        if (gd !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL ed_done_err: got %b%b expected 10", gd, er); end
        n_checks++;
        if (last_oe_run != INH + 1) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d expected %0d", last_oe_run, INH + 1); end
        tick;
        n_checks++;
        if (tx_ready !== 1'b1 || tx_done !== 1'b0) begin n_fail++; $display("FAIL ed_ready_after: got %b%b expected 10", tx_ready, tx_done); end
    endtask

    task automatic test_nack_07;
        logic [10:0] bits; logic gd, er;
        send(8'h07);
        device_xfer(1'b0, -1, bits, gd, er);
        n_checks++;
        if (bits !== 11'h40E) begin n_fail++; $display("FAIL 07_bits: got %h expected 40e", bits); end
        n_checks++;
        if (gd !== 1'b1 || er !== 1'b1) begin n_fail++; $display("FAIL 07_done_err: got %b%b expected 11", gd, er); end
    endtask

    task automatic test_timeout;
        int n;
        send(8'h5A);
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < LIMIT) begin tick; n++; end
        n_checks++;
        if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL to_start_bit: got %b expected 1", ps2_dat_oe); end
        repeat (TMO - 1) tick;
        n_checks++;
        if (tx_done !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", tx_done); end
        tick;
        n_checks++;
        if (tx_done !== 1'b1 || tx_err !== 1'b1) begin n_fail++; $display("FAIL to_done_err: got %b%b expected 11", tx_done, tx_err); end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL to_release: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
        tick;
        n_checks++;
        if (tx_ready !== 1'b1 || tx_done !== 1'b0) begin n_fail++; $display("FAIL to_ready_after: got %b%b expected 10", tx_ready, tx_done); end
    endtask

    task automatic test_glitch;
        int n;
        send(8'h55);
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < LIMIT) begin tick; n++; end
        repeat (HALF) tick;
        clk_pulse(1); repeat (30) tick;
        clk_pulse(5); repeat (30) tick;
        n_checks++;
        if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL glitch_hold0: got %b expected 1", ps2_dat_oe); end
        clk_pulse(20); repeat (30) tick;
        n_checks++;
        if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL glitch_adv1: got %b expected 0", ps2_dat_oe); end
        clk_pulse(1); repeat (30) tick;
        clk_pulse(5); repeat (30) tick;
        n_checks++;
        if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL glitch_hold1: got %b expected 0", ps2_dat_oe); end
        clk_pulse(20); repeat (30) tick;
        n_checks++;
        if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL glitch_adv2: got %b expected 1", ps2_dat_oe); end
        n = 0;
        while (tx_done !== 1'b1 && n < LIMIT) begin tick; n++; end
        n_checks++;
        if (tx_done !== 1'b1 || tx_err !== 1'b1) begin n_fail++; $display("FAIL glitch_timeout: got %b%b expected 11", tx_done, tx_err); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits; logic gd, er;
        int d0;
        send(8'h3C);
        device_xfer(1'b1, 4, bits, gd, er);
        d0 = done_cnt;
        repeat (500) tick;
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL rst_no_done: got %0d expected %0d", done_cnt, d0); end
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", tx_ready); end
        send(8'h00);
        device_xfer(1'b1, -1, bits, gd, er);
        n_checks++;
        if (bits !== 11'h600) begin n_fail++; $display("FAIL 00_bits: got %h expected 600", bits); end
        n_checks++;
        if (gd !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL 00_done_err: got %b%b expected 10", gd, er); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits; logic gd, er;
        int n, d0;
        n = 0;
        while (tx_ready !== 1'b1 && n < LIMIT) begin tick; n++; end
        d0 = done_cnt;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick;
        tx_data = 8'h3C;
        n_checks++;
        if (ps2_clk_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accept: got %b expected 1", ps2_clk_oe); end
        device_xfer(1'b1, -1, bits, gd, er);
        n_checks++;
        if (bits !== 11'h74A || gd !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %h %b%b expected 74a 10", bits, gd, er); end
        tick;
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b expected 1", tx_ready); end
        tick;
        n_checks++;
        if (tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b%b expected 01", tx_ready, ps2_clk_oe); end
        device_xfer(1'b1, -1, bits, gd, er);
        tx_valid = 1'b0;
        n_checks++;
        if (bits !== 11'h678 || gd !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got %h %b%b expected 678 10", bits, gd, er); end
        repeat (6) tick;
        n_checks++;
        if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b%b expected 10", tx_ready, ps2_clk_oe); end
        n_checks++;
        if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    endtask

    task automatic test_invariants;
        n_checks++;
        if (dbl_done != 0) begin n_fail++; $display("FAIL done_width: got %0d expected 0", dbl_done); end
        n_checks++;
        if (rdy_done != 0) begin n_fail++; $display("FAIL ready_with_done: got %0d expected 0", rdy_done); end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        test_reset;
        test_ack_ed;
        test_nack_07;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_back_to_back;
        test_invariants;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 3500, the clock-low inhibit time in clk28 cycles (125 us).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 420000, the maximum clk28 cycles allowed between device clock edges or until idle (15 ms).
REQ-003 The block SHALL have parameter FILTER_LEN, default 8, the number of consecutive equal samples needed to accept a PS/2 clock level change.
REQ-004 clk28  input  1  system clock; all logic is clocked on its rising edge.
REQ-005 rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 ps2_clk  input  1  PS/2 clock line level, asynchronous.
REQ-007 ps2_dat  input  1  PS/2 data line level, asynchronous.
REQ-008 ps2_clk_oe  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-009 ps2_dat_oe  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-010 tx_data  input  8  command byte to send to the device.
REQ-011 tx_valid  input  1  request to send tx_data.
REQ-012 tx_ready  output  1  block idle; a request is accepted when tx_valid and tx_ready are both 1.
REQ-013 tx_done  output  1  one-cycle pulse marking the end of a transfer.
REQ-014 tx_err  output  1  error flag, valid while tx_done=1 (no ACK or timeout).

Function
REQ-015 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer.
- The synchronized clock SHALL be deglitched: the filtered level changes only after FILTER_LEN consecutive equal samples.
- fall SHALL be a one-cycle pulse on a filtered 1->0 transition.
REQ-016 The FSM SHALL use states IDLE, INHIBIT, START, BITS, ACK and WAIT_IDLE.
REQ-017 IDLE behaviour:
- tx_ready=1 and both oe outputs are 0.
- On handshake in cycle N, tx_data SHALL be latched, the state becomes INHIBIT and ps2_clk_oe=1 from cycle N+1.
REQ-018 INHIBIT SHALL hold ps2_clk_oe=1 and ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START SHALL last exactly 1 cycle with ps2_clk_oe=1 and ps2_dat_oe=1 (start bit 0), then go to BITS with ps2_clk_oe=0 and ps2_dat_oe still 1.
REQ-020 BITS SHALL use a 4-bit counter k, reset to 0 on entry. On each fall pulse:
- k=0..7: ps2_dat_oe = ~tx_data[k], LSB first.
- k=8: ps2_dat_oe = ~parity, where parity = ~^tx_data (odd parity).
- k=9: ps2_dat_oe=0 (stop bit); the state becomes ACK.
- k increments after each fall pulse.
REQ-021 ACK: on the next fall pulse the synchronized ps2_dat SHALL be sampled (0 = ACK, 1 = NACK), recorded, and the state becomes WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL wait until the filtered clock and the synchronized data are both 1, then for one cycle assert tx_done=1 with tx_err = NACK, then return to IDLE.
REQ-023 A timeout counter SHALL run in BITS, ACK and WAIT_IDLE.
- It clears on state entry and on each fall pulse.
- On reaching TIMEOUT_CYCLES the block SHALL release both lines, pulse tx_done=1 with tx_err=1, and enter IDLE in the same cycle.
REQ-024 tx_valid SHALL be ignored whenever tx_ready=0.
- tx_ready SHALL be 0 from the cycle after acceptance until the cycle after tx_done.
- tx_ready and tx_done SHALL never both be 1.
REQ-025 fall pulses seen in IDLE, INHIBIT or START SHALL have no effect (device-to-host traffic is overridden by the inhibit).
REQ-026 tx_done SHALL never be high for more than one consecutive cycle.
REQ-027 A back-to-back request asserted in the tx_done cycle SHALL be accepted in the following cycle.

Reset
REQ-028 While rst=1 the block SHALL hold these values, taking effect at the next clk28 edge, including mid-transfer:
- state=IDLE
- ps2_clk_oe=0, ps2_dat_oe=0
- tx_ready=0, tx_done=0, tx_err=0
- all counters and synchronizers cleared to idle-high.
REQ-029 tx_ready SHALL become 1 in the first cycle after rst deasserts.

Verification
REQ-030 Send 0xED with a device model that ACKs:
- ps2_clk_oe is high for exactly INHIBIT_CYCLES+1 cycles.
- Data driven on the line is 0,1,0,1,1,0,1,1,1, then parity 1, then stop 1.
- Result: tx_done with tx_err=0.
REQ-031 Send 0x07 with NACK (data stays 1 at the 11th edge): parity driven 0; tx_done with tx_err=1.
REQ-032 Device never clocks after START: after TIMEOUT_CYCLES cycles, tx_done=1 with tx_err=1, lines released, tx_ready=1 the next cycle.
REQ-033 1-cycle and 5-cycle low glitches on ps2_clk during BITS: no bit advance; a 20-cycle low pulse advances exactly one bit.
REQ-034 Assert rst at bit 4 of a transfer: both oe outputs are 0 on the next cycle and no tx_done is produced; a new 0x00 transfer then completes with parity 1.
REQ-035 Hold tx_valid high continuously: exactly one transfer starts per tx_done, each begins one cycle after tx_ready returns high.
